// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the carry/borrow-lookahead adder and subtractor datapaths.
package arith_pkg;

    localparam int WIDTH_DEF = 16;

    function automatic int half_width(input int w);
        return w / 2;
    endfunction

    // Subtract form: {generate, propagate} = {~a & b, ~(a ^ b)}.
    function automatic logic [1:0] gp_sub(input logic a_bit, input logic b_bit);
        return {~a_bit & b_bit, ~(a_bit ^ b_bit)};
    endfunction

endpackage

// File: rtl/bla_slice.sv
// Combinational H-bit borrow-lookahead slice: d = a - b - bin, bout = borrow out of the top bit.
module bla_slice
    import arith_pkg::*;
#(
    parameter int H = 8
) (
    input  logic [H-1:0] a,
    input  logic [H-1:0] b,
    input  logic         bin,
    output logic [H-1:0] d,
    output logic         bout
);

    logic [H-1:0] g;
    logic [H-1:0] p;
    logic [H:0]   br;

    assign br[0] = bin;

    genvar gi;
    generate
        for (gi = 0; gi < H; gi++) begin : g_bit
            assign {g[gi], p[gi]} = gp_sub(a[gi], b[gi]);
            assign br[gi+1]       = g[gi] | (p[gi] & br[gi]);
            assign d[gi]          = a[gi] ^ b[gi] ^ br[gi];
        end
    endgenerate

    assign bout = br[H];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor with valid/ready on both sides.
// Stage 1 resolves the low half, stage 2 the high half plus borrow-out and overflow.
module cla_subtractor_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int H = half_width(WIDTH);

    logic         s1_valid_q, s1_valid_d;
    logic [H-1:0] d_lo_q, d_lo_d;
    logic         br_h_q, br_h_d;
    logic [H-1:0] a_hi_q, a_hi_d;
    logic [H-1:0] b_hi_q, b_hi_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic         s1_adv, s2_adv, accept;
    logic [H-1:0] lo_diff, hi_diff;
    logic         lo_bout, hi_bout;

    bla_slice #(.H(H)) u_lo (
        .a    (a[H-1:0]),
        .b    (b[H-1:0]),
        .bin  (bin),
        .d    (lo_diff),
        .bout (lo_bout)
    );

    bla_slice #(.H(H)) u_hi (
        .a    (a_hi_q),
        .b    (b_hi_q),
        .bin  (br_h_q),
        .d    (hi_diff),
        .bout (hi_bout)
    );

    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        accept = in_valid && s1_adv;

        s1_valid_d = s1_valid_q;
        d_lo_d     = d_lo_q;
        br_h_d     = br_h_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            d_lo_d = lo_diff;
            br_h_d = lo_bout;
            a_hi_d = a[WIDTH-1:H];
            b_hi_d = b[WIDTH-1:H];
        end

        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        // Signed overflow: operand signs differ and the result sign departs from the minuend.
        if (s2_adv && s1_valid_q) begin
            d_d    = {hi_diff, d_lo_q};
            bout_d = hi_bout;
            ovf_d  = (a_hi_q[H-1] != b_hi_q[H-1]) && (hi_diff[H-1] != a_hi_q[H-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            d_lo_q     <= '0;
            br_h_q     <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            d_lo_q     <= d_lo_d;
            br_h_q     <= br_h_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Directed and randomised-stream checks for the pipelined 16-bit borrow-lookahead subtractor.
module tb_cla_subtractor_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    cla_subtractor_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed vectors: a, b, bin -> expected d, bout, ovf (hand computed).
    logic [15:0] va   [0:6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0100, 16'h1234, 16'hFFFF, 16'h5555};
    logic [15:0] vb   [0:6] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0001, 16'h1234, 16'h0001, 16'hAAAA};
    logic        vbin [0:6] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    logic [15:0] vd   [0:6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h00FF, 16'hFFFF, 16'hFFFD, 16'hAAAB};
    logic        vbo  [0:6] = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
    logic        vov  [0:6] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1};

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || d !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b d=%h bout=%b ovf=%b, want 0 0000 0 0",
                     out_valid, d, bout, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_vectors;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = va[i]; b = vb[i]; bin = vbin[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_early_valid: got out_valid=%b one cycle after accept, want 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || d !== vd[i] || bout !== vbo[i] || ovf !== vov[i]) begin
                errors++;
                $display("FAIL vec%0d_result: %h-%h-%b got valid=%b d=%h bout=%b ovf=%b, want 1 %h %b %b",
                         i, va[i], vb[i], vbin[i], out_valid, d, bout, ovf, vd[i], vbo[i], vov[i]);
            end
            $display("vec %0d: %h - %h - %b -> d=%h bout=%b ovf=%b", i, va[i], vb[i], vbin[i], d, bout, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 16'd1; b = 16'd0; bin = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_beat1: got %b, want 1", in_ready);
        end
        @(negedge clk);
        a = 16'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_beat2: got %b, want 1", in_ready);
        end
        @(negedge clk);
        a = 16'd3;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || d !== 16'h0001) begin
            errors++;
            $display("FAIL bp_full: got in_ready=%b valid=%b d=%h, want 0 1 0001", in_ready, out_valid, d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || d !== 16'h0001) begin
            errors++;
            $display("FAIL bp_hold: got in_ready=%b d=%h, want 0 0001", in_ready, d);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_release: got %b, want 1", in_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || d !== 16'(k)) begin
                errors++;
                $display("FAIL bp_drain%0d: got valid=%b d=%h, want 1 %h", k, out_valid, d, 16'(k));
            end
            $display("bp drain %0d: d=%h", k, d);
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stream;
        logic [17:0] exp_q[$];
        logic [17:0] exp_v;
        logic [16:0] full;
        int sent = 0;
        int recv = 0;
        int cycles = 0;
        logic acc, xfer;
        while ((sent < 100 || recv < sent) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (sent < 100) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
            a         = 16'($urandom);
            b         = 16'($urandom);
            bin       = 1'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got d=%h with no beat outstanding", d);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({ovf, bout, d} !== exp_v) begin
                        errors++;
                        $display("FAIL stream_beat%0d: got d=%h bout=%b ovf=%b, want %h %b %b",
                                 recv, d, bout, ovf, exp_v[15:0], exp_v[16], exp_v[17]);
                    end
                end
                $display("stream out %0d: d=%h bout=%b ovf=%b", recv, d, bout, ovf);
                recv++;
            end
            if (acc) begin
                full  = {1'b0, a} - {1'b0, b} - {16'b0, bin};
                exp_q.push_back({(a[15] != b[15]) && (full[15] != a[15]), full[16], full[15:0]});
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 100 || recv != 100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got sent=%0d recv=%0d pending=%0d, want 100 100 0",
                     sent, recv, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight;
        int seen;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h7FFF; b = 16'hFFFF; bin = 1'b0;
        @(negedge clk);
        a = 16'h0000; b = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || d !== 16'h8000 || bout !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL rst_preload: got valid=%b d=%h bout=%b ovf=%b, want 1 8000 1 1",
                     out_valid, d, bout, ovf);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || d !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush: got valid=%b d=%h bout=%b ovf=%b, want 0 0000 0 0",
                     out_valid, d, bout, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: got %b, want 1", in_ready);
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h0005; b = 16'h0003; bin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            if (out_valid === 1'b1) begin
                seen = 1;
                checks++;
                if (d !== 16'h0002 || bout !== 1'b0 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_first_after: got d=%h bout=%b ovf=%b, want 0002 0 0", d, bout, ovf);
                end
                $display("after reset: d=%h bout=%b ovf=%b", d, bout, ovf);
            end
            @(negedge clk);
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL rst_timeout: got no result within 6 cycles, want one");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_stream();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
